mult_seq: RTL and testbench
===========================

Name: mult_seq

Overview:
- Sequential 32x32 multiplier serving MULT (signed) and MULTU (unsigned) in the multicycle CPU datapath.
- Companion to the iterative divider; the 64-bit product is written to the HI/LO registers.
- Uses a start/busy handshake identical to the divider's, so the stall logic treats both units the same way.
- Radix-2 shift-add datapath: one multiplier bit per cycle, with a final sign-correction cycle.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU.
- start  in  1  request; sampled only when busy=0.
- hi  out  WIDTH  upper half of the last completed product.
- lo  out  WIDTH  lower half of the last completed product.
- busy  out  1  high while a multiply is in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, hi=0, lo=0, counter=0, and all internal accumulator and operand registers are cleared.
- Reset asserted mid-operation aborts the operation with no partial result kept. After release, the unit is idle with hi=lo=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - On a rising edge with start=1, latch the operands:
    - mag_a = (is_signed & a[31]) ? -a : a
    - mag_b = (is_signed & b[31]) ? -b : b
    - neg = is_signed & (a[31] ^ b[31])
  - Clear the 64-bit accumulator, set counter=0, set busy=1, go to CALC.
- CALC, one iteration per cycle:
  - If mag_b[0]=1, add mag_a to the upper WIDTH+1 bits of the accumulator.
  - Shift the accumulator and mag_b right by 1; counter+1.
  - After the WIDTH-th iteration (counter reaches WIDTH), go to FIX.
- FIX:
  - {hi,lo} = neg ? (~acc + 1) : acc. Negating zero yields zero.
  - busy=0, return to IDLE.
- Latency:
  - busy is high for exactly WIDTH+1 = 33 cycles, starting on the edge after start is accepted.
  - hi/lo update on the same edge on which busy falls.
- hi/lo hold the previous result throughout busy and keep their value until the next FIX. They are never partial.
- start while busy=1 is ignored: operands are not re-latched and the timing is unchanged.
- start on the same edge busy falls is not accepted. It is accepted from the first edge with busy=0.
- Operands a, b and is_signed are sampled only on the accepting edge; later changes have no effect.
- Width rules:
  - Magnitudes are unsigned WIDTH-bit values, so 0x80000000 is a valid magnitude (2^31).
  - The accumulator adder is WIDTH+1 bits wide to hold the carry.
  - Product overflow is impossible and no flag is produced.
- No divide-by-zero analogue: zero operands take the full 33 cycles.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, CALC, FIX}
  - localparam MULT_LATENCY = WIDTH+1
  - the operand/product width constants, reused by the divider wrapper and the HI/LO write-back mux.
- One natural sub-module, multu_core: the unsigned shift-add engine (accumulator, counter, CALC sequencing).
- mult_seq wraps multu_core with operand magnitude conversion and the FIX negation, mirroring how the signed divider wraps its unsigned core.

Test Plan:
- Signed, a=3, b=-5 (0xFFFFFFFB), start pulse → busy high for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Same operands signed → hi=0x00000000, lo=0x00000001.
- Signed, a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- Back-to-back multiplies:
  - Start 7*6; at cycle 10, pulse start with a=9, b=9 → ignored, and at completion hi=0, lo=42.
  - Then start 9*9 → lo=81, and hi/lo read 42 throughout the second busy window.
- Reset mid-operation:
  - Start 0x1234*0x10, drive reset low at cycle 15 → busy=0, hi=lo=0 immediately (asynchronously).
  - After release and a new start 2*2 → lo=4 after 33 cycles.
- Zero operand, signed a=0, b=-1 → busy lasts 33 cycles; hi=lo=0, with no 0xFFFFFFFF artefact from the negation.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential multiplier and its
// neighbours in the HI/LO datapath (divider wrapper, write-back mux).
package mult_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_CNT_W   = 6;
  localparam int PROD_W       = 2 * MULT_WIDTH;
  localparam int MULT_LATENCY = MULT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_seq_if.sv
// Start/busy handshake and HI/LO result bus of the multiplier. The CPU side
// drives the request (master); the multiplier answers (slave).
interface mult_seq_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             start;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output a, b, is_signed, start,
    input  hi, lo, busy
  );

  modport slave (
    input  a, b, is_signed, start,
    output hi, lo, busy
  );

endinterface

// File: rtl/mult_seq_multu_core.sv
// Unsigned radix-2 shift-add engine: one multiplier bit per step, the partial
// sum enters at the top of the accumulator and everything shifts right.
module multu_core
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mag_a_i,
  input  logic [WIDTH-1:0]   mag_b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma_q;
  logic [WIDTH-1:0]   mb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum;

  // One iteration: conditional add into the upper WIDTH+1 bits (carry kept), then shift right
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mb_q[0] ? {1'b0, ma_q} : '0);
    acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  // Operand/accumulator/counter state; load clears, each step consumes one multiplier bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      ma_q  <= '0;
      mb_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      ma_q  <= mag_a_i;
      mb_q  <= mag_b_i;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      mb_q  <= mb_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The step taken while the counter shows WIDTH-1 is the final one
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_o  = acc_q;

endmodule

// File: rtl/mult_seq.sv
// Signed/unsigned sequential multiplier: converts operands to magnitudes,
// runs the unsigned core for WIDTH cycles, then applies the sign in FIX.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  mult_seq_if.slave  bus
);

  mult_state_e        state_q, state_d;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               load, step, wr;
  logic               last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_d;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;

  // Magnitudes are unsigned WIDTH-bit values, so -0x80000000 stays 0x80000000 (2^31)
  always_comb begin
    mag_a = (bus.is_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (bus.is_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg_d = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    prod  = neg_q ? -acc : acc;
  end

  multu_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .load_i  (load),
    .step_i  (step),
    .mag_a_i (mag_a),
    .mag_b_i (mag_b),
    .acc_o   (acc),
    .last_o  (last)
  );

  // Sequencing: start only accepted in IDLE, so requests during CALC/FIX are ignored
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_d = FIX;
      end
      FIX: begin
        wr      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched sign and HI/LO; results only written in FIX so they are never partial
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) neg_q <= neg_d;
      if (wr) {hi_q, lo_q} <= prod;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed corner cases plus random operands, checked
// against a plain 64-bit arithmetic reference.
module tb_mult_seq;
  import mult_pkg::*;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [63:0] prev;

  mult_seq_if #(.WIDTH(32)) bus ();

  mult_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clock);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(negedge clock);
    bus.start     = 1'b0;
  endtask

  // Walks the busy window, checking HI/LO hold the previous result, scrambling
  // operands, and optionally pulsing start with new operands at cycle inj.
  task automatic finish_op(input string tag, input logic [63:0] exp, input int inj,
                           input logic [31:0] ia, input logic [31:0] ib, input logic is_);
    int cycles;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      chk({tag, "_hold"}, {bus.hi, bus.lo}, prev);
      if (cycles == inj) begin
        bus.a         = ia;
        bus.b         = ib;
        bus.is_signed = is_;
        bus.start     = 1'b1;
      end else begin
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = 1'($urandom);
      end
      @(negedge clock);
      cycles++;
    end
    chk({tag, "_cycles"}, 64'(cycles), 64'(MULT_LATENCY));
    chk({tag, "_prod"}, {bus.hi, bus.lo}, exp);
    prev = exp;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    start_op(a, b, s);
    finish_op(tag, model(a, b, s), -1, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    n_chk  = 0;
    n_fail = 0;
    prev   = 64'h0;
    reset  = 1'b1;
    bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.start = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    reset = 1'b1;

    // Directed cases with hand-derived products
    start_op(32'd3, 32'hFFFFFFFB, 1'b1);
    finish_op("s3xm5", 64'hFFFFFFFF_FFFFFFF1, -1, 32'h0, 32'h0, 1'b0);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    finish_op("u_ones", 64'hFFFFFFFE_00000001, -1, 32'h0, 32'h0, 1'b0);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    finish_op("s_ones", 64'h00000000_00000001, -1, 32'h0, 32'h0, 1'b0);
    start_op(32'h80000000, 32'h80000000, 1'b1);
    finish_op("s_min", 64'h40000000_00000000, -1, 32'h0, 32'h0, 1'b0);

    // Start during busy is ignored; following op shows 42 throughout
    start_op(32'd7, 32'd6, 1'b0);
    finish_op("b2b_7x6", 64'd42, 10, 32'd9, 32'd9, 1'b0);
    start_op(32'd9, 32'd9, 1'b0);
    finish_op("b2b_9x9", 64'd81, -1, 32'h0, 32'h0, 1'b0);

    // Start held across the falling-busy edge is taken one edge later
    start_op(32'd5, 32'd7, 1'b0);
    finish_op("edge_5x7", 64'd35, 32, 32'd11, 32'd13, 1'b0);
    chk("edge_idle", 64'(bus.busy), 64'h0);
    @(negedge clock);
    bus.start = 1'b0;
    finish_op("edge_11x13", 64'd143, -1, 32'h0, 32'h0, 1'b0);

    // Zero operand, signed: no negation artefact
    start_op(32'd0, 32'hFFFFFFFF, 1'b1);
    finish_op("zero", 64'h0, -1, 32'h0, 32'h0, 1'b0);

    // Asynchronous reset mid-operation
    start_op(32'h1234, 32'h10, 1'b0);
    repeat (14) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'h0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'h0);
    prev = 64'h0;
    @(negedge clock);
    reset = 1'b1;
    run("post_rst", 32'd2, 32'd2, 1'b0);

    // Random operands, mixed signedness
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (i == 0) ra = 32'h80000000;
      if (i == 1) rb = 32'h7FFFFFFF;
      run($sformatf("rnd%0d", i), ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
